// File: rtl/imm_encoder_if.sv
// Handshake bundle between the immediate encoder and its producer/consumer.
// Field names follow the block's port list so traces line up with the documentation.
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_imm;
  logic [2:0]  in_sel;
  logic [31:0] in_tmpl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [1:0]  out_err;

  modport master (
    output in_valid, in_imm, in_sel, in_tmpl, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, in_imm, in_sel, in_tmpl, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );
endinterface

// File: rtl/imm_encoder.sv
// Scatters a signed immediate into RISC-V instruction fields for the given ImmSel type.
// Two-stage valid/ready pipeline: stage 1 range/alignment check, stage 2 field packing.
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  imm_encoder_if.slave     bus,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [2:0] {
    SEL_I = 3'b001,
    SEL_S = 3'b010,
    SEL_B = 3'b011,
    SEL_J = 3'b100,
    SEL_U = 3'b101
  } imm_sel_e;

  typedef enum logic [1:0] {
    ERR_OK    = 2'b00,
    ERR_RANGE = 2'b01,
    ERR_ALIGN = 2'b10,
    ERR_SEL   = 2'b11
  } err_e;

  logic              s1_valid_q, s2_valid_q;
  logic [2:0]        s1_sel_q;
  logic [31:0]       s1_imm_q, s1_tmpl_q;
  err_e              s1_err_q, s1_err_d;
  logic [31:0]       s2_instr_q, s2_instr_d;
  err_e              s2_err_q;
  logic [CNT_W-1:0]  enc_q, enc_d, err_q, err_d;

  logic              s1_advance, accept, xfer;
  logic              sel_legal, in_range, aligned;
  logic signed [31:0] imm_s;
  logic [31:0]       mask, fields;

  assign s1_advance   = ~s2_valid_q | bus.out_ready;
  assign bus.in_ready = ~s1_valid_q | s1_advance;
  assign accept       = bus.in_valid & bus.in_ready;
  assign xfer         = s2_valid_q & bus.out_ready;
  assign imm_s        = $signed(bus.in_imm);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sel_legal = 1'b1;
    in_range  = 1'b0;
    aligned   = 1'b1;
    case (bus.in_sel)
      SEL_I, SEL_S: in_range = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
      SEL_B: begin
        in_range = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094);
        aligned  = ~bus.in_imm[0];
      end
      SEL_J: begin
        in_range = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574);
        aligned  = ~bus.in_imm[0];
      end
      SEL_U:   in_range = (imm_s >= -32'sd524288) && (imm_s <= 32'sd524287);
      default: sel_legal = 1'b0;
    endcase

    if (!sel_legal)     s1_err_d = ERR_SEL;
    else if (!in_range) s1_err_d = ERR_RANGE;
    else if (!aligned)  s1_err_d = ERR_ALIGN;
    else                s1_err_d = ERR_OK;
  end

  always_comb begin
    mask   = 32'h0;
    fields = 32'h0;
    case (s1_sel_q)
      SEL_I: begin
        mask   = 32'hFFF0_0000;
        fields = {s1_imm_q[11:0], 20'b0};
      end
      SEL_S: begin
        mask   = 32'hFE00_0F80;
        fields = {s1_imm_q[11:5], 13'b0, s1_imm_q[4:0], 7'b0};
      end
      SEL_B: begin
        mask   = 32'hFE00_0F80;
        fields = {s1_imm_q[12], s1_imm_q[10:5], 13'b0, s1_imm_q[4:1], s1_imm_q[11], 7'b0};
      end
      SEL_J: begin
        mask   = 32'hFFFF_F000;
        fields = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12], 12'b0};
      end
      SEL_U: begin
        mask   = 32'hFFFF_F000;
        fields = {s1_imm_q[19:0], 12'b0};
      end
      default: ;
    endcase

    // Illegal sel passes the template through untouched; range/alignment errors zero the fields.
    case (s1_err_q)
      ERR_OK:  s2_instr_d = (s1_tmpl_q & ~mask) | fields;
      ERR_SEL: s2_instr_d = s1_tmpl_q;
      default: s2_instr_d = s1_tmpl_q & ~mask;
    endcase
  end

  always_comb begin
    enc_d = enc_q;
    err_d = err_q;
    if (clr_cnt) begin
      enc_d = '0;
      err_d = '0;
    end else if (xfer) begin
      if (enc_q != '1)                   enc_d = enc_q + CNT_W'(1);
      if (s2_err_q != ERR_OK && err_q != '1) err_d = err_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: data registers are reset as well, because out_instr/out_err must read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sel_q   <= 3'b0;
      s1_imm_q   <= 32'h0;
      s1_tmpl_q  <= 32'h0;
      s1_err_q   <= ERR_OK;
      s2_valid_q <= 1'b0;
      s2_instr_q <= 32'h0;
      s2_err_q   <= ERR_OK;
      enc_q      <= '0;
      err_q      <= '0;
    end else begin
      if (bus.in_ready) s1_valid_q <= bus.in_valid;
      if (accept) begin
        s1_sel_q  <= bus.in_sel;
        s1_imm_q  <= bus.in_imm;
        s1_tmpl_q <= bus.in_tmpl;
        s1_err_q  <= s1_err_d;
      end
      if (s1_advance) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_instr_q <= s2_instr_d;
          s2_err_q   <= s1_err_q;
        end
      end
      enc_q <= enc_d;
      err_q <= err_d;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_instr = s2_instr_q;
  assign bus.out_err   = s2_err_q;
  assign enc_count     = enc_q;
  assign err_count     = err_q;

endmodule
